// File: rtl/lfsr_pkg.sv
// Shared constants and types for the LFSR test controller.
package lfsr_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned LOSS_W  = 8;

    // Controller state encoding, visible on o_state.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_SEED      = 3'd1,
        ST_SOFT_RST  = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_RUN       = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    // States that time themselves with the shared cycle counter.
    function automatic logic is_timed(input state_t s);
        return (s == ST_WAIT_LOCK) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/lfsr_sat_counter.sv
// Up-counter with synchronous clear, enable and optional saturation at all-ones.
module lfsr_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             sat,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic at_max;

    assign at_max = (count == MAX_VAL);

    // Clear wins over enable; saturating mode holds at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !(sat && at_max)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/lfsr_test_ctrl.sv
// Sequences seed load, generator soft reset, lock wait and a timed run window
// for an LFSR generator/checker pair, and reports pass/timeout/loss results.
module lfsr_test_ctrl
    import lfsr_pkg::*;
#(
    parameter int unsigned LFSR_WIDTH   = 8,
    parameter int unsigned LOCK_TIMEOUT = 64,
    parameter int unsigned LEN_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [LFSR_WIDTH-1:0] i_seed,
    input  logic [LEN_WIDTH-1:0]  i_test_len,
    input  logic                  i_lock,
    output logic [LFSR_WIDTH-1:0] o_seed,
    output logic                  o_valid,
    output logic                  o_soft_reset,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic                  o_timeout,
    output logic [LOSS_W-1:0]     o_loss_cnt,
    output logic [STATE_W-1:0]    o_state
);

    // Cycle counter must reach both LOCK_TIMEOUT-1 and the largest run length.
    localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned CNT_W = (LEN_WIDTH > TO_W) ? LEN_WIDTH : TO_W;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    state_t state;
    state_t next_state;

    logic [LFSR_WIDTH-1:0] seed_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  timeout_q;
    logic                  pass_q;

    logic [CNT_W-1:0]  cyc_cnt;
    logic [LOSS_W-1:0] loss_cnt;

    logic accept;
    logic aborting;
    logic timeout_set;
    logic cyc_clr;
    logic cyc_en;
    logic loss_en;
    logic enter_done;
    logic run_last;

    assign accept     = (state == ST_IDLE) && i_start;
    assign aborting   = i_abort && (state != ST_IDLE) && (state != ST_DONE);
    assign run_last   = (cyc_cnt == (CNT_W'(len_q) - CNT_W'(1)));
    assign enter_done = (next_state == ST_DONE) && (state != ST_DONE);

    // State register.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; an abort overrides everything except DONE.
    always_comb begin
        next_state  = state;
        timeout_set = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i_start) begin
                    next_state = ST_SEED;
                end
            end
            ST_SEED: begin
                next_state = ST_SOFT_RST;
            end
            ST_SOFT_RST: begin
                next_state = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (i_lock) begin
                    next_state = (len_q == '0) ? ST_DONE : ST_RUN;
                end else if (cyc_cnt == TO_LAST) begin
                    next_state  = ST_DONE;
                    timeout_set = 1'b1;
                end
            end
            ST_RUN: begin
                if (run_last) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        if (aborting) begin
            next_state  = ST_IDLE;
            timeout_set = 1'b0;
        end
    end

    // Shared cycle counter restarts on every state change, so it reads 0 on entry.
    assign cyc_clr = (next_state != state);
    assign cyc_en  = is_timed(state);

    lfsr_sat_counter #(
        .WIDTH (CNT_W)
    ) u_cyc_cnt (
        .clk   (clk),
        .rst   (i_reset),
        .clr   (cyc_clr),
        .en    (cyc_en),
        .sat   (1'b1),
        .count (cyc_cnt)
    );

    // Lock-loss counter: cleared by a new test, saturates at 255.
    assign loss_en = (state == ST_RUN) && !i_lock && !aborting;

    lfsr_sat_counter #(
        .WIDTH (LOSS_W)
    ) u_loss_cnt (
        .clk   (clk),
        .rst   (i_reset),
        .clr   (accept),
        .en    (loss_en),
        .sat   (1'b1),
        .count (loss_cnt)
    );

    // Test parameters and result flags; pass is resolved on the way into DONE.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            seed_q    <= '0;
            len_q     <= '0;
            timeout_q <= 1'b0;
            pass_q    <= 1'b0;
        end else if (accept) begin
            seed_q    <= i_seed;
            len_q     <= i_test_len;
            timeout_q <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
            if (aborting) begin
                pass_q <= 1'b0;
            end else if (enter_done) begin
                pass_q <= !timeout_set && !timeout_q && (loss_cnt == '0) && !loss_en;
            end
        end
    end

    // Outputs come straight from registers or decode of the state register.
    assign o_state      = state;
    assign o_seed       = seed_q;
    assign o_valid      = (state == ST_SEED);
    assign o_soft_reset = (state == ST_SOFT_RST);
    assign o_busy       = (state != ST_IDLE);
    assign o_done       = (state == ST_DONE);
    assign o_pass       = pass_q;
    assign o_timeout    = timeout_q;
    assign o_loss_cnt   = loss_cnt;

endmodule

// File: tb/tb_lfsr_test_ctrl.sv
// Directed plus randomized bench for lfsr_test_ctrl against an outcome model.
module tb_lfsr_test_ctrl;

    logic        clk;
    logic        i_reset;
    logic        i_start;
    logic        i_abort;
    logic [7:0]  i_seed;
    logic [15:0] i_test_len;
    logic        i_lock;
    logic [7:0]  o_seed;
    logic        o_valid;
    logic        o_soft_reset;
    logic        o_busy;
    logic        o_done;
    logic        o_pass;
    logic        o_timeout;
    logic [7:0]  o_loss_cnt;
    logic [2:0]  o_state;

    int errors = 0;
    int checks = 0;

    lfsr_test_ctrl #(
        .LFSR_WIDTH   (8),
        .LOCK_TIMEOUT (64),
        .LEN_WIDTH    (16)
    ) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_seed       (i_seed),
        .i_test_len   (i_test_len),
        .i_lock       (i_lock),
        .o_seed       (o_seed),
        .o_valid      (o_valid),
        .o_soft_reset (o_soft_reset),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_pass       (o_pass),
        .o_timeout    (o_timeout),
        .o_loss_cnt   (o_loss_cnt),
        .o_state      (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one test. Lock rises on WAIT_LOCK cycle index d (never if d >= 64);
    // during RUN, lock is low on run cycles [ds, ds+dl) or on all of them.
    task automatic run_test(input string name, input logic [7:0] seed, input int len,
                            input int d, input int ds, input int dl, input bit all_low);
        int  nv, ns, nw, nr, nd, both, low_cnt;
        int  exp_wait, exp_run, exp_loss;
        bit  exp_to, exp_pass, seen_done, got_pass, got_to;
        logic [7:0] got_seed, got_loss;
        // Outcome model from the controller's rules.
        exp_to   = (d >= 64);
        exp_wait = exp_to ? 64 : d + 1;
        exp_run  = exp_to ? 0 : len;
        low_cnt  = 0;
        for (int k = 0; k < len; k++) begin
            if (all_low || (k >= ds && k < ds + dl)) low_cnt++;
        end
        exp_loss = exp_to ? 0 : ((low_cnt > 255) ? 255 : low_cnt);
        exp_pass = !exp_to && (exp_loss == 0);

        nv = 0; ns = 0; nw = 0; nr = 0; nd = 0; both = 0;
        seen_done = 1'b0; got_pass = 1'b0; got_to = 1'b0;
        got_seed = 8'h00; got_loss = 8'h00;

        i_seed     = seed;
        i_test_len = 16'(len);
        i_start    = 1'b1;
        i_lock     = 1'b0;
        step();
        i_start = 1'b0;
        i_seed  = ~seed;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (o_valid && o_soft_reset) both++;
            if (o_valid) begin
                nv++;
                got_seed = o_seed;
            end
            if (o_soft_reset) ns++;
            i_lock = 1'b0;
            if (o_state == 3'd3) begin
                i_lock = (nw >= d);
                nw++;
            end else if (o_state == 3'd4) begin
                i_lock = !(all_low || (nr >= ds && nr < ds + dl));
                nr++;
            end
            if (o_done) begin
                nd++;
                seen_done = 1'b1;
                got_pass  = o_pass;
                got_to    = o_timeout;
                got_loss  = o_loss_cnt;
            end
            if (seen_done && o_state == 3'd0) break;
            step();
        end
        chk({name, ":done_seen"}, 32'(seen_done), 32'd1);
        chk({name, ":valid_cnt"}, 32'(nv), 32'd1);
        chk({name, ":seed"}, 32'(got_seed), 32'(seed));
        chk({name, ":softrst_cnt"}, 32'(ns), 32'd1);
        chk({name, ":strobe_overlap"}, 32'(both), 32'd0);
        chk({name, ":wait_cycles"}, 32'(nw), 32'(exp_wait));
        chk({name, ":run_cycles"}, 32'(nr), 32'(exp_run));
        chk({name, ":done_pulses"}, 32'(nd), 32'd1);
        chk({name, ":pass"}, 32'(got_pass), 32'(exp_pass));
        chk({name, ":timeout"}, 32'(got_to), 32'(exp_to));
        chk({name, ":loss"}, 32'(got_loss), 32'(exp_loss));
        step();
        chk({name, ":idle_busy"}, 32'(o_busy), 32'd0);
        chk({name, ":held_loss"}, 32'(o_loss_cnt), 32'(exp_loss));
        chk({name, ":held_pass"}, 32'(o_pass), 32'(exp_pass));
    endtask

    initial begin
        int nd;
        i_reset    = 1'b1;
        i_start    = 1'b0;
        i_abort    = 1'b0;
        i_seed     = 8'h00;
        i_test_len = 16'd0;
        i_lock     = 1'b0;
        #23;
        chk("reset:state", 32'(o_state), 32'd0);
        chk("reset:seed", 32'(o_seed), 32'd0);
        chk("reset:busy", 32'(o_busy), 32'd0);
        chk("reset:flags", {28'd0, o_valid, o_soft_reset, o_done, o_pass}, 32'd0);
        chk("reset:loss", 32'(o_loss_cnt), 32'd0);
        @(negedge clk);
        i_reset = 1'b0;
        step();

        run_test("basic", 8'hA5, 16, 3, 0, 0, 1'b0);
        run_test("timeout", 8'h5A, 16, 1000, 0, 0, 1'b0);
        run_test("loss5", 8'hC3, 32, 2, 10, 5, 1'b0);
        run_test("saturate", 8'h81, 300, 0, 0, 0, 1'b1);
        run_test("len0", 8'h42, 0, 2, 0, 0, 1'b0);
        run_test("late_lock", 8'h17, 4, 63, 0, 0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            run_test($sformatf("rand%0d", t), 8'($urandom), int'($urandom_range(0, 40)),
                     int'($urandom_range(0, 70)), int'($urandom_range(0, 40)),
                     int'($urandom_range(0, 10)), ($urandom_range(0, 7) == 0));
        end

        // Abort on RUN cycle 4, with an ignored start request earlier in RUN.
        begin
            int nr;
            bit hit;
            nr = 0;
            hit = 1'b0;
            i_seed = 8'h3C; i_test_len = 16'd20; i_start = 1'b1; i_lock = 1'b0;
            step();
            i_start = 1'b0;
            for (int cyc = 0; cyc < 200; cyc++) begin
                i_start = 1'b0;
                i_lock  = (o_state == 3'd3) || (o_state == 3'd4);
                if (o_state == 3'd4) begin
                    if (nr == 2) begin
                        i_start = 1'b1;
                        i_seed  = 8'hEE;
                    end
                    if (nr == 4) begin
                        hit = 1'b1;
                        i_abort = 1'b1;
                        step();
                        break;
                    end
                    nr++;
                end
                step();
            end
            i_abort = 1'b0;
            i_start = 1'b0;
            chk("abort:reached", 32'(hit), 32'd1);
            chk("abort:state", 32'(o_state), 32'd0);
            chk("abort:busy", 32'(o_busy), 32'd0);
            chk("abort:done", 32'(o_done), 32'd0);
            chk("abort:pass", 32'(o_pass), 32'd0);
            chk("abort:seed_kept", 32'(o_seed), 32'h3C);
            nd = 0;
            for (int k = 0; k < 6; k++) begin
                step();
                if (o_done) nd++;
            end
            chk("abort:no_done", 32'(nd), 32'd0);
        end

        // Asynchronous reset in the middle of WAIT_LOCK.
        i_seed = 8'h99; i_test_len = 16'd8; i_start = 1'b1; i_lock = 1'b0;
        step();
        i_start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("rst_mid:in_wait", 32'(o_state), 32'd3);
        #2;
        i_reset = 1'b1;
        #1;
        chk("rst_mid:state", 32'(o_state), 32'd0);
        chk("rst_mid:seed", 32'(o_seed), 32'd0);
        chk("rst_mid:busy", 32'(o_busy), 32'd0);
        chk("rst_mid:status", {29'd0, o_done, o_pass, o_timeout}, 32'd0);
        @(negedge clk);
        i_reset = 1'b0;
        i_seed  = 8'h11;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("rst_mid:restart_state", 32'(o_state), 32'd1);
        chk("rst_mid:restart_seed", 32'(o_seed), 32'h11);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("rst_mid:abort_idle", 32'(o_state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
